// File: rtl/alu_nibble_scheduler_if.sv
// alu_nibble_scheduler_if
//   Bundles the two request ports, the response port, the shared ALU slice
//   port and the busy flag of alu_nibble_scheduler.
//   slave  : the scheduler itself.
//   master : the environment (requesters, response consumer, ALU slice).
//   Build option: ALU_SCHED_FLAGS_EN adds rsp_zero / rsp_carry.
interface alu_nibble_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SCHED_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_carry;
`endif

  logic [3:0]       slice_x;
  logic [3:0]       slice_y;
  logic [2:0]       slice_op;
  logic             slice_cin;
  logic [3:0]       slice_o;
  logic             slice_cout;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
`ifdef ALU_SCHED_FLAGS_EN
    output rsp_zero, rsp_carry,
`endif
    input  rsp_ready,
    output slice_x, slice_y, slice_op, slice_cin,
    input  slice_o, slice_cout,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
`ifdef ALU_SCHED_FLAGS_EN
    input  rsp_zero, rsp_carry,
`endif
    output rsp_ready,
    input  slice_x, slice_y, slice_op, slice_cin,
    output slice_o, slice_cout,
    input  busy
  );
endinterface

// File: rtl/alu_nibble_scheduler.sv
// alu_nibble_scheduler
//   Shares one external combinational 4-bit ALU slice between two requesters.
//   Round-robin arbitration; a granted WIDTH-bit op runs nibble-serial, LSB
//   nibble first, one nibble per clock, with the ripple carry registered
//   between nibbles. The result is returned on a valid/ready response port.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts any op in flight)
//   bus  : alu_nibble_scheduler_if.slave (requests, response, slice, busy)
// Build option
//   ALU_SCHED_FLAGS_EN : adds rsp_zero and rsp_carry, registered with rsp_data.
//
// state | meaning
// IDLE  | waiting for a request; grant decided combinationally
// EXEC  | one nibble through the slice per clock
// RESP  | result held on the response port until taken
module alu_nibble_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_nibble_scheduler_if.slave bus
);
  localparam int NNIB = WIDTH / 4;
  localparam int NW   = $clog2(NNIB);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH-1:0] data_q;
  logic [NW-1:0]    nib_q;
  logic             carry_q;
  logic             id_q;
  logic             last_grant_q;
`ifdef ALU_SCHED_FLAGS_EN
  logic             zero_q;
  logic             cflag_q;
`endif

  logic             grant;
  logic             accept;
  logic             last_nib;
  logic             is_arith;
  logic [NW+1:0]    shamt;
  logic [3:0]       a_nib, b_nib;

  // Round robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  // Ready is held low while rst is asserted even though state is already IDLE.
  assign bus.req0_ready = (state_q == IDLE) && !rst && bus.req0_valid && !grant;
  assign bus.req1_ready = (state_q == IDLE) && !rst && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign shamt    = {nib_q, 2'b00};
  assign a_nib    = 4'(a_q >> shamt);
  assign b_nib    = 4'(b_q >> shamt);
  assign last_nib = (nib_q == NW'(NNIB - 1));
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Slice drive: SUB is ADD of ~b with carry seeded to 1, NOT a is XOR with
  // all-ones, PASS a is OR with zero.
  always_comb begin
    bus.slice_x   = 4'h0;
    bus.slice_y   = 4'h0;
    bus.slice_op  = 3'b000;
    bus.slice_cin = 1'b0;
    if (state_q == EXEC) begin
      bus.slice_x = a_nib;
      case (op_q)
        OP_SUB: begin
          bus.slice_op  = OP_ADD;
          bus.slice_y   = ~b_nib;
          bus.slice_cin = carry_q;
        end
        OP_ADD: begin
          bus.slice_op  = OP_ADD;
          bus.slice_y   = b_nib;
          bus.slice_cin = carry_q;
        end
        OP_NOTA: begin
          bus.slice_op = OP_XOR;
          bus.slice_y  = 4'hF;
        end
        OP_PASS: begin
          bus.slice_op = OP_OR;
          bus.slice_y  = 4'h0;
        end
        default: begin
          bus.slice_op = op_q;
          bus.slice_y  = b_nib;
        end
      endcase
    end
  end

  assign acc_next = (acc_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(bus.slice_o) << shamt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (last_nib) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      data_q       <= '0;
      nib_q        <= '0;
      carry_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
      zero_q       <= 1'b0;
      cflag_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q         <= grant ? bus.req1_op : bus.req0_op;
            a_q          <= grant ? bus.req1_a  : bus.req0_a;
            b_q          <= grant ? bus.req1_b  : bus.req0_b;
            carry_q      <= ((grant ? bus.req1_op : bus.req0_op) == OP_SUB);
            nib_q        <= '0;
            id_q         <= grant;
            last_grant_q <= grant;
          end
        end
        EXEC: begin
          acc_q   <= acc_next;
          carry_q <= bus.slice_cout;
          nib_q   <= nib_q + 1'b1;
          if (last_nib) begin
            data_q  <= acc_next;
`ifdef ALU_SCHED_FLAGS_EN
            zero_q  <= (acc_next == '0);
            cflag_q <= is_arith ? bus.slice_cout : 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef ALU_SCHED_FLAGS_EN
  logic unused_arith;
  assign unused_arith = is_arith;
`else
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_carry = cflag_q;
`endif

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_nibble_scheduler.sv
module tb_alu_nibble_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic last_grant_m = 1'b1;

  alu_nibble_scheduler_if #(.WIDTH(16)) bus ();

  alu_nibble_scheduler #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit slice.
  logic [4:0] s_sum;
  always_comb begin
    s_sum = 5'd0;
    case (bus.slice_op)
      3'b000: s_sum = {1'b0, bus.slice_x & bus.slice_y};
      3'b001: s_sum = {1'b0, bus.slice_x | bus.slice_y};
      3'b010: s_sum = {1'b0, bus.slice_x ^ bus.slice_y};
      3'b011: s_sum = {1'b0, ~(bus.slice_x ^ bus.slice_y)};
      3'b100: s_sum = {1'b0, bus.slice_x} + {1'b0, bus.slice_y} + {4'd0, bus.slice_cin};
      default: s_sum = 5'd0;
    endcase
    bus.slice_o    = s_sum[3:0];
    bus.slice_cout = s_sum[4];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: {carry, data}
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~(a ^ b)};
      3'd4: return {1'b0, a} + {1'b0, b};
      3'd5: return {(a >= b), 16'(a - b)};
      3'd6: return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic drive(input int id, input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic do_op(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input bit hold);
    logic [16:0] m;
    int k;
    bit ok;
    m = model(op, a, b);
    drive(id, 1'b1, op, a, b);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy(id)) begin ok = 1; break; end
    end
    chk("accept", 32'(ok), 32'd1);
    if (!ok) begin
      drive(id, 1'b0, 3'd0, 16'd0, 16'd0);
      return;
    end
    if (hold) bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(id, 1'b0, 3'd0, 16'd0, 16'd0);
    last_grant_m = id[0];
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin k = i; break; end
    end
    chk("latency", 32'(k), 32'd4);
    chk("rsp_data", 32'(bus.rsp_data), 32'(m[15:0]));
    chk("rsp_id", 32'(bus.rsp_id), 32'(id));
`ifdef ALU_SCHED_FLAGS_EN
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(m[15:0] == 16'd0));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(m[16]));
`endif
    if (hold) begin
      drive(1 - id, 1'b1, 3'd0, 16'h1234, 16'h5678);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_data", 32'(bus.rsp_data), 32'(m[15:0]));
        chk("hold_id", 32'(bus.rsp_id), 32'(id));
        chk("hold_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      drive(1 - id, 1'b0, 3'd0, 16'd0, 16'd0);
      chk("hold_release", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
    end else begin
      @(posedge clk); #1;
      chk("to_idle", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    int dual, nrsp;
    logic exp_id;

    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    bus.rsp_ready = 1'b1;

    // Reset state, with a request present to show ready is held low.
    #12;
    drive(1, 1'b1, 3'd4, 16'h1111, 16'h2222);
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("rst_slice", {20'd0, bus.slice_x, bus.slice_y, bus.slice_op, bus.slice_cin}, 32'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    @(negedge clk); rst = 1'b0;

    // Valid raised and dropped between edges: nothing latched.
    @(posedge clk); #1;
    drive(1, 1'b1, 3'd4, 16'h0001, 16'h0001);
    #3;
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    @(posedge clk); #1;
    chk("drop_busy", 32'(bus.busy), 32'd0);

    do_op(0, 3'd3, 16'hF0F0, 16'hFF00, 0);
    chk("xnor_abs", 32'(bus.rsp_data), 32'h0000F00F);
    do_op(1, 3'd4, 16'h0FFF, 16'h0001, 0);
    chk("add_ripple", 32'(bus.rsp_data), 32'h00001000);
    do_op(1, 3'd4, 16'hFFFF, 16'h0001, 0);
    do_op(0, 3'd5, 16'h0005, 16'h0007, 0);
    chk("sub_neg", 32'(bus.rsp_data), 32'h0000FFFE);
    do_op(0, 3'd5, 16'h0007, 16'h0005, 0);
    do_op(0, 3'd6, 16'h5A3C, 16'h0000, 0);
    do_op(1, 3'd7, 16'hBEEF, 16'h1234, 0);
    do_op(1, 3'd1, 16'hA0A0, 16'h0505, 1);

    // Reset during nibble 2 aborts the op.
    drive(0, 1'b1, 3'd4, 16'h0A00, 16'h0100);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("nib2_x", 32'(bus.slice_x), 32'h0000000A);
    #2 rst = 1'b1;
    #1;
    chk("abort_slice", {20'd0, bus.slice_x, bus.slice_y, bus.slice_op, bus.slice_cin}, 32'd0);
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    last_grant_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_norsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Both requesting continuously: alternate grants starting with req0.
    for (int i = 0; i < 2; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      drive(i, 1'b1, 3'd0, ra[i], rb[i]);
    end
    dual = 0;
    nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) dual++;
      if (bus.rsp_valid) begin
        exp_id = ~last_grant_m;
        chk("rr_id", 32'(bus.rsp_id), 32'(exp_id));
        chk("rr_data", 32'(bus.rsp_data), 32'(model(3'd0, ra[exp_id], rb[exp_id]) & 17'h0FFFF));
        last_grant_m = exp_id;
        nrsp++;
      end
    end
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    chk("rr_count", 32'(nrsp), 32'd4);
    chk("dual_ready", 32'(dual), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++)
      do_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
